// File: rtl/vertex_stream_packer.sv
// Purpose : packs a stream of FP32 component words (x,y,z[,w]) into tagged vec4 vertices
//           for the 4x4 matrix-vector transform front end; 3-component mode forces w=1.0.
// Latency : out_valid is high the cycle after the handshake of a vertex's last component.
// Backpr. : accepts words only in RUN (s_ready from state register); output has no backpressure.
// Ports   : i_clk/i_rst (async active-high); i_start/i_vert_count/i_comp3 batch launch;
//           o_busy/o_done batch status; i_s_valid/o_s_ready/i_s_data component stream;
//           o_out_valid/o_out_vertex_id/o_vx..o_vw assembled vertex stream.
module vertex_stream_packer #(
  parameter int IDW = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic [IDW-1:0] i_vert_count,
  input  logic           i_comp3,
  output logic           o_busy,
  output logic           o_done,
  input  logic           i_s_valid,
  output logic           o_s_ready,
  input  logic [31:0]    i_s_data,
  output logic           o_out_valid,
  output logic [IDW-1:0] o_out_vertex_id,
  output logic [31:0]    o_vx,
  output logic [31:0]    o_vy,
  output logic [31:0]    o_vz,
  output logic [31:0]    o_vw
);

  localparam logic [31:0] FP_ONE = 32'h3F80_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;

  logic [IDW-1:0] r_remaining;
  logic           r_comp3;
  logic [1:0]     r_idx;
  logic [IDW-1:0] r_id;
  logic [31:0]    r_slot0;
  logic [31:0]    r_slot1;
  logic [31:0]    r_slot2;

  logic           r_out_valid;
  logic           r_done;
  logic [IDW-1:0] r_out_id;
  logic [31:0]    r_vx;
  logic [31:0]    r_vy;
  logic [31:0]    r_vz;
  logic [31:0]    r_vw;

  logic           w_start_acc;
  logic           w_hs;
  logic [1:0]     w_last_idx;
  logic           w_vtx_done;
  logic           w_batch_end;

  // s_ready is a pure decode of the state register: no path from s_valid.
  assign o_s_ready   = (r_state == S_RUN);
  assign o_busy      = (r_state == S_RUN);

  assign w_start_acc = i_start & (r_state == S_IDLE);
  assign w_hs        = i_s_valid & o_s_ready;
  assign w_last_idx  = r_comp3 ? 2'd2 : 2'd3;
  assign w_vtx_done  = w_hs & (r_idx == w_last_idx);
  assign w_batch_end = w_vtx_done & (r_remaining == IDW'(1));

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = (i_vert_count == '0) ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        if (w_batch_end) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: component slots, counters and registered vertex outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_remaining <= '0;
      r_comp3     <= 1'b0;
      r_idx       <= 2'd0;
      r_id        <= '0;
      r_slot0     <= 32'h0;
      r_slot1     <= 32'h0;
      r_slot2     <= 32'h0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      r_out_id    <= '0;
      r_vx        <= 32'h0;
      r_vy        <= 32'h0;
      r_vz        <= 32'h0;
      r_vw        <= 32'h0;
    end else begin
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      if (w_start_acc) begin
        r_remaining <= i_vert_count;
        r_comp3     <= i_comp3;
        r_idx       <= 2'd0;
        r_id        <= '0;
        // Empty batch: done coincides with the single FIN cycle.
        if (i_vert_count == '0) begin
          r_done <= 1'b1;
        end
      end else if (w_hs) begin
        if (!w_vtx_done) begin
          case (r_idx)
            2'd0:    r_slot0 <= i_s_data;
            2'd1:    r_slot1 <= i_s_data;
            default: r_slot2 <= i_s_data;
          endcase
          r_idx <= r_idx + 2'd1;
        end else begin
          // Final word bypasses the slots so the vertex emits with no extra cycle.
          r_vx <= r_slot0;
          r_vy <= r_slot1;
          if (r_comp3) begin
            r_vz <= i_s_data;
            r_vw <= FP_ONE;
          end else begin
            r_vz <= r_slot2;
            r_vw <= i_s_data;
          end
          r_out_valid <= 1'b1;
          r_out_id    <= r_id;
          r_idx       <= 2'd0;
          r_id        <= r_id + IDW'(1);
          r_remaining <= r_remaining - IDW'(1);
          if (w_batch_end) begin
            r_done <= 1'b1;
          end
        end
      end
    end
  end

  assign o_out_valid     = r_out_valid;
  assign o_done          = r_done;
  assign o_out_vertex_id = r_out_id;
  assign o_vx            = r_vx;
  assign o_vy            = r_vy;
  assign o_vz            = r_vz;
  assign o_vw            = r_vw;

endmodule

// File: tb/tb_vertex_stream_packer.sv
// Purpose : directed self-checking bench for vertex_stream_packer.
// Latency : inputs change 1ns after a rising edge; outputs sampled 1ns after the edge.
// Backpr. : the bench only drives words while s_ready is expected high.
module tb_vertex_stream_packer;

  localparam int IDW = 8;

  logic           clk;
  logic           rst;
  logic           start;
  logic [IDW-1:0] vert_count;
  logic           comp3;
  logic           busy;
  logic           done;
  logic           s_valid;
  logic           s_ready;
  logic [31:0]    s_data;
  logic           out_valid;
  logic [IDW-1:0] out_vertex_id;
  logic [31:0]    vx, vy, vz, vw;

  int checks = 0;
  int errors = 0;

  vertex_stream_packer #(.IDW(IDW)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_start         (start),
    .i_vert_count    (vert_count),
    .i_comp3         (comp3),
    .o_busy          (busy),
    .o_done          (done),
    .i_s_valid       (s_valid),
    .o_s_ready       (s_ready),
    .i_s_data        (s_data),
    .o_out_valid     (out_valid),
    .o_out_vertex_id (out_vertex_id),
    .o_vx            (vx),
    .o_vy            (vy),
    .o_vz            (vz),
    .o_vw            (vw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [IDW-1:0] cnt, input logic c3);
    start      = 1'b1;
    vert_count = cnt;
    comp3      = c3;
    tick();
    start      = 1'b0;
  endtask

  task automatic chk_vec(input string tag, input logic [IDW-1:0] id,
                         input logic [31:0] ex, input logic [31:0] ey,
                         input logic [31:0] ez, input logic [31:0] ew);
    chk({tag, "_id"}, 32'(out_vertex_id), 32'(id));
    chk({tag, "_vx"}, vx, ex);
    chk({tag, "_vy"}, vy, ey);
    chk({tag, "_vz"}, vz, ez);
    chk({tag, "_vw"}, vw, ew);
  endtask

  logic [31:0] words8 [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                              32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
  logic        bub_v  [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [31:0] bub_d  [7] = '{32'h11111111, 32'hDEADBEEF, 32'hDEADBEEF, 32'h22222222,
                              32'hDEADBEEF, 32'h33333333, 32'h44444444};

  initial begin
    rst = 1'b1; start = 1'b0; vert_count = '0; comp3 = 1'b0;
    s_valid = 1'b0; s_data = 32'h0;
    repeat (2) tick();

    // Reset state
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sready", 32'(s_ready), 32'd0);
    chk("rst_ovalid", 32'(out_valid), 32'd0);
    chk_vec("rst", 8'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    rst = 1'b0;
    tick();
    chk("idle_sready", 32'(s_ready), 32'd0);

    // Full batch, 2 vertices, 4 components, back-to-back, with a stray start
    launch(8'd2, 1'b0);
    chk("fb_busy", 32'(busy), 32'd1);
    chk("fb_sready", 32'(s_ready), 32'd1);
    for (int k = 0; k < 8; k++) begin
      s_valid = 1'b1;
      s_data  = words8[k];
      if (k == 4) begin
        start = 1'b1; vert_count = 8'd7; comp3 = 1'b1;
      end
      tick();
      start = 1'b0;
      chk($sformatf("fb_ovalid%0d", k), 32'(out_valid), 32'((k == 3) || (k == 7)));
      chk($sformatf("fb_done%0d", k), 32'(done), 32'(k == 7));
      if (k == 3) chk_vec("fb_v0", 8'd0, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000);
      if (k == 7) chk_vec("fb_v1", 8'd1, 32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000);
    end
    chk("fb_end_busy", 32'(busy), 32'd0);
    chk("fb_end_sready", 32'(s_ready), 32'd0);
    s_valid = 1'b0;
    tick();
    chk("fb_post_ovalid", 32'(out_valid), 32'd0);
    chk("fb_post_done", 32'(done), 32'd0);
    chk("fb_hold_vx", vx, 32'h40A00000);
    chk("fb_hold_id", 32'(out_vertex_id), 32'd1);

    // comp3 mode
    launch(8'd1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      s_valid = 1'b1;
      s_data  = words8[k];
      tick();
      chk($sformatf("c3_ovalid%0d", k), 32'(out_valid), 32'(k == 2));
    end
    s_valid = 1'b0;
    chk("c3_done", 32'(done), 32'd1);
    chk_vec("c3", 8'd0, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h3F800000);
    tick();

    // Bubbles on s_valid
    launch(8'd1, 1'b0);
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("bub_sready%0d", k), 32'(s_ready), 32'd1);
      s_valid = bub_v[k];
      s_data  = bub_d[k];
      tick();
      chk($sformatf("bub_ovalid%0d", k), 32'(out_valid), 32'(k == 6));
    end
    s_valid = 1'b0;
    chk("bub_done", 32'(done), 32'd1);
    chk_vec("bub", 8'd0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    tick();

    // Empty batch
    s_valid = 1'b1; s_data = 32'hCAFEF00D;
    launch(8'd0, 1'b0);
    chk("emp_done", 32'(done), 32'd1);
    chk("emp_ovalid", 32'(out_valid), 32'd0);
    chk("emp_sready", 32'(s_ready), 32'd0);
    tick();
    chk("emp_done2", 32'(done), 32'd0);
    chk("emp_ovalid2", 32'(out_valid), 32'd0);
    chk("emp_sready2", 32'(s_ready), 32'd0);
    chk("emp_hold_vx", vx, 32'h11111111);
    s_valid = 1'b0;
    tick();

    // Reset mid-batch: asynchronous clear, partial vertex dropped
    launch(8'd3, 1'b0);
    for (int k = 0; k < 2; k++) begin
      s_valid = 1'b1;
      s_data  = words8[k];
      tick();
    end
    s_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_sready", 32'(s_ready), 32'd0);
    chk("arst_vx", vx, 32'h0);
    chk("arst_vw", vw, 32'h0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("arst_ovalid%0d", k), 32'(out_valid), 32'd0);
      chk($sformatf("arst_done%0d", k), 32'(done), 32'd0);
    end

    // Fresh batch after reset
    launch(8'd1, 1'b0);
    for (int k = 4; k < 8; k++) begin
      s_valid = 1'b1;
      s_data  = words8[k];
      tick();
    end
    s_valid = 1'b0;
    chk("post_ovalid", 32'(out_valid), 32'd1);
    chk("post_done", 32'(done), 32'd1);
    chk_vec("post", 8'd0, 32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vertex_stream_packer.md
# vertex_stream_packer

Front-end feeder for the FP32 4x4 matrix-vector transform pipeline. Accepts a batch of vertex components one 32-bit FP32 word per cycle over a valid/ready stream and assembles each group into a vec4. Tags each vec4 with a sequential vertex ID and drives it as a single-cycle-valid, no-backpressure vertex stream (valid, ID, x/y/z/w) into the transform's input. Supports 3-component input with w forced to 1.0.

## Interface
- IDW, 8, width of vertex ID and of the batch vertex count
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; asynchronous, active-high
- start  in  1  single-cycle batch launch; ignored unless idle
- vert_count  in  IDW  vertices in batch, sampled on accepted start; 0 is legal
- comp3  in  1  1 = 3 words per vertex (x,y,z), w = 32'h3F800000; sampled on accepted start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  single-cycle pulse at batch completion
- s_valid  in  1  component word valid
- s_ready  out  1  packer can accept a component word
- s_data  in  32  FP32 component, order x,y,z[,w]
- out_valid  out  1  assembled vertex valid, one cycle per vertex
- out_vertex_id  out  IDW  vertex index within batch, 0..vert_count-1
- vx, vy, vz, vw  out  32 each  assembled FP32 vec4

## Operation
- FSM states: IDLE, RUN, FIN.
- IDLE: s_ready=0, busy=0. On start=1, latch vert_count into a remaining counter and comp3 into a mode flag, and clear the component index and vertex ID counters.
  - vert_count!=0 -> RUN.
  - vert_count==0 -> FIN.
- RUN: s_ready=1 every cycle, driven from the state register only, with no combinational path from s_valid.
  - A handshake (s_valid & s_ready) stores s_data into the component slot selected by a 2-bit index, then increments the index.
  - Last component of a vertex is index 3 (comp3=0) or index 2 (comp3=1). On its handshake, in the same edge:
    - load vx/vy/vz from the held slots and the final word directly from s_data;
    - in comp3 mode, vz<=s_data and vw<=32'h3F800000;
    - set out_valid<=1 and out_vertex_id<=current ID;
    - reset the index to 0, increment the ID, decrement the remaining count.
  - When remaining==1 at that handshake, the state goes to IDLE and done<=1 in the same edge, so done coincides with the final out_valid.
- FIN: entered only for vert_count==0. Asserts done for one cycle with no out_valid, then returns to IDLE.
- out_valid and done are one-cycle pulses. vx..vw and out_vertex_id hold their last values after out_valid drops.
- start is ignored in RUN and FIN. Batch parameters cannot change mid-batch.
- Extra s_valid words outside RUN are not accepted (s_ready=0). The upstream holds them.
- ID counter wraps naturally at IDW bits. The maximum batch (2^IDW-1) never wraps.

## Timing
- Reset values of all outputs: busy=0, done=0, s_ready=0, out_valid=0, out_vertex_id=0, vx=vy=vz=vw=32'h0. FSM=IDLE, counters=0.
- Reset asserted mid-batch clears immediately and asynchronously. The partial vertex is discarded and no out_valid or done is produced.
- start accepted at edge N: busy=1 and s_ready=1 from cycle N+1 (or FIN at N+1 and done at N+1 for vert_count=0).
- Latency: out_valid is high the cycle after the final-component handshake.
- Peak throughput: one vertex per 4 cycles (3 in comp3 mode), with no idle cycle between vertices or between a vertex and the next first word.
- Bubbles on s_valid stall assembly only. Components already held are retained indefinitely.
- On the final vertex edge: busy falls, s_ready falls, done=1 and out_valid=1 together. A new start is accepted the next cycle.

## Test plan
- Reset: assert rst asynchronously mid-cycle -> all outputs 0 immediately; s_ready=0 while idle.
- Full batch: start with vert_count=2, comp3=0. Stream 3F800000, 40000000, 40400000, 40800000, 40A00000, 40C00000, 40E00000, 41000000 back-to-back ->
  - first out_valid 1 cycle after word 4: ID 0, vec 1,2,3,4;
  - second out_valid 4 cycles later: ID 1, vec 5,6,7,8, with done=1 in the same cycle;
  - a start pulsed mid-batch is ignored.
- comp3 mode: vert_count=1, comp3=1, words 3F800000, 40000000, 40400000 -> out_valid with vx=3F800000, vy=40000000, vz=40400000, vw=3F800000, done same cycle.
- Bubbles: vert_count=1, s_valid toggling 1,0,0,1,0,1,1 -> exactly one out_valid, one cycle after the 4th handshake; s_ready stays 1 throughout.
- Empty batch: start with vert_count=0 -> done pulses on cycle N+1, out_valid never asserts, s_ready never asserts.
- Reset mid-batch: vert_count=3, reset after 2 words accepted -> no out_valid or done. A new batch with vert_count=1 then emits ID 0 with correct data.
